// File: rtl/pll_lock_controller_if.sv
// pll_lock_controller_if: control inputs and status outputs of the PLL lock controller
interface pll_lock_controller_if #(
   parameter int CNT_WIDTH   = 12,
   parameter int RETRY_WIDTH = 3
);
   logic                   startCalibration;
   logic                   autoRecalEnable;
   logic [CNT_WIDTH-1:0]   calibrationTime;
   logic [CNT_WIDTH-1:0]   lockTime;
   logic [CNT_WIDTH-1:0]   lockTimeout;
   logic [3:0]             unlockTolerance;
   logic [RETRY_WIDTH-1:0] maxRetry;
   logic                   instantLock;
   logic                   pllCalibrationEnable;
   logic                   pllCalibrationDone;
   logic                   pllLocked;
   logic                   lossOfLock;
   logic                   lockFail;
   logic [RETRY_WIDTH-1:0] retryCount;
   logic [2:0]             state;
   modport master (
      output startCalibration, autoRecalEnable, calibrationTime, lockTime, lockTimeout,
             unlockTolerance, maxRetry, instantLock,
      input  pllCalibrationEnable, pllCalibrationDone, pllLocked, lossOfLock, lockFail,
             retryCount, state
   );
   modport slave (
      input  startCalibration, autoRecalEnable, calibrationTime, lockTime, lockTimeout,
             unlockTolerance, maxRetry, instantLock,
      output pllCalibrationEnable, pllCalibrationDone, pllLocked, lossOfLock, lockFail,
             retryCount, state
   );
endinterface

// File: rtl/pll_lock_controller.sv
// pll_lock_controller: PLL calibration sequencing, lock qualification, retry and loss-of-lock supervision
module pll_lock_controller #(
   parameter int CNT_WIDTH   = 12,
   parameter int RETRY_WIDTH = 3,
   parameter int SYNC_STAGES = 2
) (
   input logic clk40Ref,
   input logic asynReset,
   pll_lock_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE = 3'd0, CALIB = 3'd1, WAITLOCK = 3'd2, LOCKED = 3'd3, FAIL = 3'd4} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_WIDTH-1:0] cal_cnt, lock_cnt, to_cnt, drop_cnt;
   logic [RETRY_WIDTH-1:0] retry_q, retry_d;
   logic lock_sync, start_prev, start_pulse;
   logic done_q, done_d, loss_q, loss_d;
   logic lock_hit, timeout_hit, drop_hit, enter;
   assign lock_sync   = sync_q[SYNC_STAGES-1];
   assign start_pulse = bus.startCalibration & ~start_prev;
   assign lock_hit    = lock_sync && lock_cnt == bus.lockTime;
   assign timeout_hit = to_cnt == bus.lockTimeout;
   assign drop_hit    = !lock_sync && drop_cnt == CNT_WIDTH'(bus.unlockTolerance);
   assign enter       = start_pulse || state_d != state_q;
   assign bus.pllCalibrationEnable = state_q == CALIB;
   assign bus.pllLocked            = state_q == LOCKED;
   assign bus.lockFail             = state_q == FAIL;
   assign bus.pllCalibrationDone   = done_q;
   assign bus.lossOfLock           = loss_q;
   assign bus.retryCount           = retry_q;
   assign bus.state                = state_q;
   // bring the asynchronous lock indication into the clock domain and remember the previous start level
   always_ff @(posedge clk40Ref or posedge asynReset) begin
      if (asynReset) begin
         sync_q     <= '0;
         start_prev <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.instantLock};
         start_prev <= bus.startCalibration;
      end
   end
   // next state, retry count, done flag and loss pulse; a start pulse overrides everything
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      done_d  = done_q;
      loss_d  = 1'b0;
      if (start_pulse) begin
         state_d = CALIB;
         retry_d = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, FAIL: ;
            CALIB: if (cal_cnt == bus.calibrationTime) begin
               state_d = WAITLOCK;
               done_d  = 1'b1;
            end
            WAITLOCK: if (lock_hit) begin
               state_d = LOCKED;
               retry_d = '0;
            end else if (timeout_hit) begin
               state_d = retry_q == bus.maxRetry ? FAIL : CALIB;
               retry_d = retry_q == bus.maxRetry ? retry_q : retry_q + 1'b1;
               done_d  = retry_q == bus.maxRetry;
            end
            LOCKED: if (drop_hit) begin
               loss_d  = 1'b1;
               state_d = bus.autoRecalEnable ? CALIB : IDLE;
               done_d  = bus.autoRecalEnable ? 1'b0 : done_q;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   // registered state and status
   always_ff @(posedge clk40Ref or posedge asynReset) begin
      if (asynReset) begin
         state_q <= IDLE;
         retry_q <= '0;
         done_q  <= 1'b0;
         loss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         done_q  <= done_d;
         loss_q  <= loss_d;
      end
   end
   // per-state timers, all cleared on any state entry
   always_ff @(posedge clk40Ref or posedge asynReset) begin
      if (asynReset) begin
         cal_cnt  <= '0;
         lock_cnt <= '0;
         to_cnt   <= '0;
         drop_cnt <= '0;
      end else if (enter) begin
         cal_cnt  <= '0;
         lock_cnt <= '0;
         to_cnt   <= '0;
         drop_cnt <= '0;
      end else begin
         cal_cnt  <= cal_cnt + CNT_WIDTH'(state_q == CALIB);
         to_cnt   <= to_cnt + CNT_WIDTH'(state_q == WAITLOCK);
         lock_cnt <= state_q == WAITLOCK ? (lock_sync ? lock_cnt + 1'b1 : '0) : lock_cnt;
         drop_cnt <= state_q == LOCKED ? (lock_sync ? '0 : drop_cnt + 1'b1) : drop_cnt;
      end
   end
endmodule

// File: tb/tb_pll_lock_controller.sv
// tb_pll_lock_controller: scoreboard of expected state transitions checked against the controller
module tb_pll_lock_controller;
   localparam int SYNC_STAGES = 2;
   localparam logic [2:0] S_IDLE = 3'd0, S_CALIB = 3'd1, S_WAIT = 3'd2, S_LOCKED = 3'd3, S_FAIL = 3'd4;
   typedef struct packed {
      logic [2:0]  st;
      logic [15:0] dwell;
      logic [2:0]  retry;
      logic        done;
      logic        loss;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int errors = 0;
   int dwell = 0;
   logic [2:0] prev_st = S_IDLE;
   exp_t q[$];
   exp_t e;
   pll_lock_controller_if bus ();
   pll_lock_controller #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk40Ref(clk),
      .asynReset(rst),
      .bus(bus)
   );
   always #12.5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [2:0] st, input int dw, input logic [2:0] r, input logic d, input logic l);
      q.push_back('{st: st, dwell: 16'(dw), retry: r, done: d, loss: l});
   endtask
   task automatic start();
      bus.startCalibration = 1'b1;
      cyc(1);
      bus.startCalibration = 1'b0;
   endtask
   task automatic wait_state(input logic [2:0] s, input int budget);
      int n = 0;
      while (bus.state !== s && n < budget) begin
         cyc(1);
         n++;
      end
      chk("wait_state", bus.state, s);
   endtask
   // every state change pops the next expected transition and checks dwell time and status
   always @(negedge clk) begin
      if (bus.state !== prev_st) begin
         if (q.size() == 0) chk("unexpected_transition", 32'(q.size()), 1);
         else begin
            e = q.pop_front();
            chk("state", bus.state, e.st);
            if (e.dwell != 0) chk("dwell", dwell, e.dwell);
            chk("retry", bus.retryCount, e.retry);
            chk("cal_done", bus.pllCalibrationDone, e.done);
            chk("loss", bus.lossOfLock, e.loss);
            chk("cal_en", bus.pllCalibrationEnable, e.st == S_CALIB);
            chk("locked", bus.pllLocked, e.st == S_LOCKED);
            chk("lock_fail", bus.lockFail, e.st == S_FAIL);
         end
         prev_st = bus.state;
         dwell = 1;
      end else dwell++;
   end
   initial begin
      bus.startCalibration = 1'b0;
      bus.autoRecalEnable  = 1'b1;
      bus.calibrationTime  = 12'd123;
      bus.lockTime         = 12'd235;
      bus.lockTimeout      = 12'd1000;
      bus.unlockTolerance  = 4'd3;
      bus.maxRetry         = 3'd2;
      bus.instantLock      = 1'b1;
      #200;
      chk("rst_state", bus.state, S_IDLE);
      chk("rst_outputs", {bus.pllCalibrationEnable, bus.pllCalibrationDone, bus.pllLocked,
                          bus.lossOfLock, bus.lockFail, bus.retryCount}, 0);
      @(negedge clk) rst = 1'b0;
      cyc(2);
      push(S_CALIB, 0, 0, 0, 0);
      start();
      wait_state(S_CALIB, 5);
      cyc(10);
      push(S_IDLE, 0, 0, 0, 0);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_state", bus.state, S_IDLE);
      chk("async_rst_cal_en", bus.pllCalibrationEnable, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cyc(2);
      push(S_CALIB, 0, 0, 0, 0);
      push(S_WAIT, 124, 0, 1, 0);
      push(S_LOCKED, 236, 0, 1, 0);
      start();
      wait_state(S_LOCKED, 500);
      cyc(3);
      push(S_CALIB, 0, 0, 0, 0);
      push(S_WAIT, 124, 0, 1, 0);
      push(S_LOCKED, 437, 0, 1, 0);
      start();
      wait_state(S_WAIT, 200);
      cyc(200 - SYNC_STAGES);
      bus.instantLock = 1'b0;
      cyc(1);
      bus.instantLock = 1'b1;
      wait_state(S_LOCKED, 600);
      cyc(5);
      bus.instantLock = 1'b0;
      cyc(3);
      bus.instantLock = 1'b1;
      cyc(SYNC_STAGES + 4);
      chk("short_drop_locked", bus.pllLocked, 1);
      chk("short_drop_no_loss", bus.lossOfLock, 0);
      push(S_CALIB, 0, 0, 0, 1);
      push(S_WAIT, 124, 0, 1, 0);
      push(S_LOCKED, 236, 0, 1, 0);
      bus.instantLock = 1'b0;
      cyc(4);
      bus.instantLock = 1'b1;
      wait_state(S_CALIB, 20);
      chk("loss_pulse", bus.lossOfLock, 1);
      cyc(1);
      chk("loss_one_cycle", bus.lossOfLock, 0);
      wait_state(S_LOCKED, 600);
      cyc(5);
      bus.autoRecalEnable = 1'b0;
      push(S_IDLE, 0, 0, 1, 1);
      bus.instantLock = 1'b0;
      cyc(4);
      bus.instantLock = 1'b1;
      wait_state(S_IDLE, 20);
      cyc(1);
      chk("idle_loss_one_cycle", bus.lossOfLock, 0);
      bus.instantLock = 1'b0;
      cyc(5);
      push(S_CALIB, 0, 0, 0, 0);
      push(S_WAIT, 124, 0, 1, 0);
      push(S_CALIB, 1001, 1, 0, 0);
      push(S_WAIT, 124, 1, 1, 0);
      push(S_CALIB, 1001, 2, 0, 0);
      push(S_WAIT, 124, 2, 1, 0);
      push(S_FAIL, 1001, 2, 1, 0);
      start();
      wait_state(S_FAIL, 4000);
      cyc(10);
      chk("fail_hold", bus.lockFail, 1);
      push(S_CALIB, 0, 0, 0, 0);
      push(S_WAIT, 124, 0, 1, 0);
      start();
      wait_state(S_WAIT, 200);
      cyc(500);
      push(S_CALIB, 501, 0, 0, 0);
      push(S_WAIT, 124, 0, 1, 0);
      start();
      chk("abort_done_clear", bus.pllCalibrationDone, 0);
      wait_state(S_WAIT, 200);
      cyc(5);
      chk("queue_empty", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/pll_lock_controller.md
# pll_lock_controller

Parametrised calibration and lock-supervision controller for the ETROC2 readout clocking path. It sequences PLL calibration, qualifies the asynchronous `instantLock` indication against programmable windows, retries failed locks, and detects and optionally recovers from loss of lock. It generalises the fixed calibrate-then-lock flow of `simplePLL`, adding a lock timeout, bounded retries, an unlock tolerance window, auto-recalibration and status reporting. Clocked by the 40 MHz reference; drives the PLL model's calibration enable and feeds status to slow control.

## Interface
- `CNT_WIDTH`, 12, width of all time counters and time inputs.
- `RETRY_WIDTH`, 3, width of the retry counter and `maxRetry`.
- `SYNC_STAGES`, 2, flip-flop stages on the `instantLock` synchroniser; legal values are 2 or more.

- `clk40Ref` in 1: the single clock; all state updates on its rising edge.
- `asynReset` in 1: asynchronous, active-high reset.
- `startCalibration` in 1: synchronous to `clk40Ref`; a rising edge starts or restarts calibration.
- `autoRecalEnable` in 1: on loss of lock, 1 recalibrates and 0 returns to IDLE.
- `calibrationTime` in CNT_WIDTH: CALIB lasts `calibrationTime`+1 cycles.
- `lockTime` in CNT_WIDTH: number of consecutive synchronised-lock cycles needed to declare lock.
- `lockTimeout` in CNT_WIDTH: WAITLOCK cycle budget before a retry.
- `unlockTolerance` in 4: number of consecutive unlock cycles tolerated while LOCKED.
- `maxRetry` in RETRY_WIDTH: number of recalibrations allowed after the first attempt.
- `instantLock` in 1: asynchronous lock indication from the PLL.
- `pllCalibrationEnable` out 1: high while in CALIB.
- `pllCalibrationDone` out 1: sticky; set on exit from CALIB, cleared on entry to CALIB.
- `pllLocked` out 1: high while in LOCKED.
- `lossOfLock` out 1: one-cycle pulse when lock is lost.
- `lockFail` out 1: high while in FAIL.
- `retryCount` out RETRY_WIDTH: number of retries used in the current attempt.
- `state` out 3: IDLE=0, CALIB=1, WAITLOCK=2, LOCKED=3, FAIL=4.

## Operation
- **Synchroniser.** `instantLock` passes through SYNC_STAGES flops. The last stage is `lockSync`; all decisions use `lockSync`.
- **Start detection.** `startPulse` = `startCalibration` & ~`startPrev`, where `startPrev` is registered. `startPulse` has priority over every other transition in every state. It enters CALIB, clears the counters and sets `retryCount`=0.
- **IDLE.** Waits for `startPulse`.
- **CALIB.**
  - `calCnt` increments from 0 each cycle.
  - When `calCnt`==`calibrationTime`, go to WAITLOCK and set `pllCalibrationDone`.
- **WAITLOCK.**
  - `lockCnt` increments while `lockSync`=1 and clears to 0 when `lockSync`=0.
  - `toCnt` increments every cycle.
  - When `lockSync`=1 and `lockCnt`==`lockTime`, go to LOCKED and clear `retryCount`.
  - Otherwise, when `toCnt`==`lockTimeout`:
    - if `retryCount`==`maxRetry`, go to FAIL;
    - else increment `retryCount` and go to CALIB.
  - If lock qualification and timeout occur in the same cycle, the lock wins.
- **LOCKED.**
  - `dropCnt` increments while `lockSync`=0 and clears when `lockSync`=1.
  - When `lockSync`=0 and `dropCnt`==`unlockTolerance`, lock is lost: pulse `lossOfLock` for 1 cycle, then go to CALIB if `autoRecalEnable`=1, else to IDLE.
  - `pllCalibrationDone` remains set on a transition to IDLE.
- **FAIL.** Remains in FAIL until `startPulse`.
- **Counter widths.** Counters are CNT_WIDTH wide and compare by equality only. They are cleared on every state entry and never wrap.
- **Reset.** All outputs, counters, `startPrev` and the synchroniser flops are 0, and `state`=IDLE. Asserting `asynReset` mid-operation forces this immediately, without waiting for a clock edge.

## Timing
- **Start.** `state`=CALIB on the first edge where `startCalibration`=1 and `startPrev`=0.
- **CALIB duration.** `pllCalibrationEnable` is high for exactly `calibrationTime`+1 cycles. `calibrationTime`=0 gives 1 cycle.
- **Lock input latency.** A change on `instantLock` reaches `lockSync` after SYNC_STAGES edges.
- **Lock qualification.** With `lockSync` steady at 1 on WAITLOCK entry, `pllLocked` rises `lockTime`+1 cycles after entry.
- **Timeout.** With `lockSync`=0, WAITLOCK lasts `lockTimeout`+1 cycles.
- **Loss detection.** Loss is declared after `unlockTolerance`+1 consecutive `lockSync`=0 cycles. `lossOfLock` is registered and asserts in the same cycle that `state` leaves LOCKED.
- **Output timing.** All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset.** Assert `asynReset` for 200 ns, then assert it again mid-CALIB -> all outputs 0 and `state`=0, with no clock edge needed.
- **Nominal lock.** `calibrationTime`=123, `lockTime`=235, `instantLock`=1, pulse start -> `pllCalibrationEnable` high for 124 cycles; `pllCalibrationDone`=1; `pllLocked` rises 236 cycles after WAITLOCK entry; `retryCount`=0.
- **Glitch in WAITLOCK.** Drop `instantLock` for 1 cycle at lock count 200 -> lock count restarts; `pllLocked` is delayed by the glitch plus 236 cycles.
- **Retry exhaustion.** `instantLock`=0, `lockTimeout`=1000, `maxRetry`=2 -> 3 CALIB entries; `retryCount` steps 0, 1, 2; then FAIL with `lockFail`=1. A following start pulse -> CALIB, `retryCount`=0.
- **Loss of lock.** `unlockTolerance`=3:
  - a 3-cycle drop -> `pllLocked` stays 1;
  - a 4-cycle drop -> `lossOfLock` pulses 1 cycle, then CALIB with `autoRecalEnable`=1, or IDLE with `autoRecalEnable`=0.
- **Start abort.** Start pulse during WAITLOCK at `toCnt`=500 -> CALIB on the next edge; `pllCalibrationDone`=0; counters cleared.
